// File: rtl/move_scan_controller.sv
// Sequences one move-generation pass over the 64 square units: reset, wait for done,
// then drain every square FIFO in order and stream its valid moves to the consumer.
module move_scan_controller #(
  parameter int GEN_TIMEOUT = 64,
  parameter int MOVE_W      = 19,
  parameter int SLOTS       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       sqDone,
  input  logic [63:0]       sqEmpty,
  input  logic [159:0]      sqFifoOut,
  output logic              sqReset,
  output logic [5:0]        sqSel,
  output logic [63:0]       sqRden,
  output logic [MOVE_W-1:0] mvData,
  output logic              mvValid,
  input  logic              mvReady,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        moveCount
);

  localparam int BUF_W  = MOVE_W * SLOTS;
  localparam int CNT_W  = $clog2(GEN_TIMEOUT + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [2:0] {IDLE, CLR, GEN, SCAN, READ, LATCH, EMIT, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   gen_cnt;
  logic [BUF_W-1:0]   word_buf;
  logic [SLOT_W-1:0]  slot;
  logic [MOVE_W-1:0]  cur;
  logic               gen_finished;
  logic               gen_expire;
  logic               slot_last;
  logic               slot_done;
  logic               pad_unused;

  assign pad_unused = ^sqFifoOut[159:BUF_W];
  assign cur        = word_buf[slot*MOVE_W +: MOVE_W];

  // Done flags are stale for the first two GEN cycles while squares leave reset.
  assign gen_finished = (gen_cnt >= CNT_W'(2)) && (&sqDone);
  assign gen_expire   = (gen_cnt == CNT_W'(GEN_TIMEOUT - 2));
  assign slot_last    = (slot == SLOT_W'(SLOTS - 1));
  assign slot_done    = cur[MOVE_W-1] || (mvValid && mvReady);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLR;
      CLR:     state_next = GEN;
      GEN:     if (gen_finished || gen_expire) state_next = SCAN;
      SCAN: begin
        if (!sqEmpty[sqSel])      state_next = READ;
        else if (sqSel == 6'd63)  state_next = DONE;
      end
      READ:    state_next = LATCH;
      LATCH:   state_next = EMIT;
      EMIT:    if (slot_done && slot_last) state_next = SCAN;
      DONE:    if (start) state_next = CLR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sqReset = (state == CLR);
    sqRden  = (state == READ) ? (64'd1 << sqSel) : 64'd0;
    busy    = (state != IDLE) && (state != DONE);
    done    = (state == DONE);
  end

  // A valid move is loaded into the output register once, then held until accepted;
  // returning to SCAN keeps sqSel because the same square may hold further words.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_cnt   <= '0;
      word_buf  <= '0;
      slot      <= '0;
      sqSel     <= '0;
      mvValid   <= 1'b0;
      mvData    <= '0;
      timeout   <= 1'b0;
      moveCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            moveCount <= '0;
            timeout   <= 1'b0;
            sqSel     <= '0;
          end
        end
        CLR: gen_cnt <= '0;
        GEN: begin
          if (!gen_finished) begin
            gen_cnt <= gen_cnt + 1'b1;
            if (gen_expire) timeout <= 1'b1;
          end
        end
        SCAN: begin
          if (sqEmpty[sqSel] && (sqSel != 6'd63)) sqSel <= sqSel + 6'd1;
        end
        LATCH: begin
          word_buf <= sqFifoOut[BUF_W-1:0];
          slot     <= '0;
        end
        EMIT: begin
          if (cur[MOVE_W-1]) begin
            slot <= slot + 1'b1;
          end else if (!mvValid) begin
            mvValid <= 1'b1;
            mvData  <= cur;
          end else if (mvReady) begin
            mvValid <= 1'b0;
            slot    <= slot + 1'b1;
            if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scan_controller.sv
// Self-checking bench for move_scan_controller: table of passes with a square FIFO model
// and a scoreboard of expected moves, plus a reset-during-emit sequence.
module tb_move_scan_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  sqDone;
  logic [63:0]  sqEmpty;
  logic [159:0] sqFifoOut;
  logic         sqReset;
  logic [5:0]   sqSel;
  logic [63:0]  sqRden;
  logic [18:0]  mvData;
  logic         mvValid;
  logic         mvReady;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [7:0]   moveCount;

  move_scan_controller #(.GEN_TIMEOUT(64), .MOVE_W(19), .SLOTS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sqDone(sqDone), .sqEmpty(sqEmpty),
    .sqFifoOut(sqFifoOut), .sqReset(sqReset), .sqSel(sqSel), .sqRden(sqRden),
    .mvData(mvData), .mvValid(mvValid), .mvReady(mvReady), .busy(busy), .done(done),
    .timeout(timeout), .moveCount(moveCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sq;
    int         nwords;
    logic [7:0] mask;
    int         stall;
    bit         stuck;
    int         exp_moves;
    int         exp_reads;
    bit         exp_timeout;
    int         exp_lat;
  } vec_t;

  vec_t         vecs[6];
  int           checks = 0;
  int           failures = 0;
  int           cycle = 0;
  int           rd_count = 0;
  int           stall_left = 0;
  bit           ready_default = 1'b1;
  bit           prev_hold = 1'b0;
  logic [18:0]  prev_data = '0;
  logic [159:0] word_q[$];
  int           word_sq[$];
  logic [18:0]  exp_q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] move_of(input int s, input int seed);
    return {7'b0010000, 6'(12 + s + seed * 8), 6'(20 + s + seed)};
  endfunction

  function automatic logic [159:0] make_word(input logic [7:0] mask, input int seed);
    logic [159:0] w;
    w = '0;
    w[159:152] = 8'hA5;
    for (int s = 0; s < 8; s++) begin
      if (mask[s]) w[s*19 +: 19] = move_of(s, seed);
      else         w[s*19 +: 19] = {1'b1, 18'(s * 1234 + seed * 77)};
    end
    return w;
  endfunction

  task automatic update_empty();
    sqEmpty = '1;
    foreach (word_sq[i]) sqEmpty[word_sq[i]] = 1'b0;
  endtask

  // One clock: handshake decision for the coming edge, scoreboard pop, FIFO model.
  task automatic tick();
    logic [18:0] exp;
    @(negedge clk);
    cycle++;
    if (!reset && prev_hold) begin
      checkOutput("hold_valid", 64'(mvValid), 64'd1);
      checkOutput("hold_data", 64'(mvData), 64'(prev_data));
    end
    if (mvValid && stall_left > 0) begin
      mvReady = 1'b0;
      stall_left--;
    end else begin
      mvReady = ready_default;
    end
    if (!reset && mvValid && mvReady) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_move", 64'(mvData), 64'h7FFFF);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("move_data", 64'(mvData), 64'(exp));
      end
    end
    prev_hold = !reset && mvValid && !mvReady;
    prev_data = mvData;
    if (!reset && sqRden != 64'd0) begin
      rd_count++;
      checkOutput("rden_onehot", sqRden, 64'd1 << sqSel);
      if (word_q.size() > 0) begin
        checkOutput("rden_square", 64'(sqSel), 64'(word_sq[0]));
        sqFifoOut = word_q.pop_front();
        void'(word_sq.pop_front());
      end else begin
        checkOutput("rden_nonempty", 64'd0, 64'd1);
      end
    end
    update_empty();
  endtask

  task automatic load_square(input int sq, input int nwords, input logic [7:0] mask);
    for (int w = 0; w < nwords; w++) begin
      word_q.push_back(make_word(mask, w));
      word_sq.push_back(sq);
      for (int s = 0; s < 8; s++)
        if (mask[s]) exp_q.push_back(move_of(s, w));
    end
    update_empty();
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    sqDone        = v.stuck ? ~(64'd1 << 40) : '1;
    stall_left    = v.stall;
    ready_default = 1'b1;
    rd_count      = 0;
    load_square(v.sq, v.nwords, v.mask);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("clr_sqreset", 64'(sqReset), 64'd1);
    checkOutput("clr_busy", 64'(busy), 64'd1);
    checkOutput("clr_timeout", 64'(timeout), 64'd0);
    checkOutput("clr_movecount", 64'(moveCount), 64'd0);
    lat = 0;
    while (!done && lat < 2000) begin
      tick();
      lat++;
    end
    checkOutput("done_reached", 64'(done), 64'd1);
    if (v.exp_lat >= 0) checkOutput("done_latency", 64'(lat), 64'(v.exp_lat));
    checkOutput("move_count", 64'(moveCount), 64'(v.exp_moves));
    checkOutput("read_count", 64'(rd_count), 64'(v.exp_reads));
    checkOutput("timeout_flag", 64'(timeout), 64'(v.exp_timeout));
    checkOutput("moves_left", 64'(exp_q.size()), 64'd0);
    checkOutput("final_sel", 64'(sqSel), 64'd63);
    checkOutput("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{sq: 0,  nwords: 0, mask: 8'h00, stall: 0, stuck: 0, exp_moves: 0,  exp_reads: 0, exp_timeout: 0, exp_lat: 68};
    vecs[1] = '{sq: 12, nwords: 1, mask: 8'h21, stall: 0, stuck: 0, exp_moves: 2,  exp_reads: 1, exp_timeout: 0, exp_lat: -1};
    vecs[2] = '{sq: 12, nwords: 1, mask: 8'h21, stall: 5, stuck: 0, exp_moves: 2,  exp_reads: 1, exp_timeout: 0, exp_lat: -1};
    vecs[3] = '{sq: 63, nwords: 2, mask: 8'hFF, stall: 0, stuck: 0, exp_moves: 16, exp_reads: 2, exp_timeout: 0, exp_lat: -1};
    vecs[4] = '{sq: 0,  nwords: 0, mask: 8'h00, stall: 0, stuck: 1, exp_moves: 0,  exp_reads: 0, exp_timeout: 1, exp_lat: -1};
    vecs[5] = '{sq: 0,  nwords: 0, mask: 8'h00, stall: 0, stuck: 0, exp_moves: 0,  exp_reads: 0, exp_timeout: 0, exp_lat: 68};

    reset     = 1'b1;
    start     = 1'b0;
    sqDone    = '1;
    sqEmpty   = '1;
    sqFifoOut = '0;
    mvReady   = 1'b1;
    tick();
    tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_valid", 64'(mvValid), 64'd0);
    checkOutput("rst_sqreset", 64'(sqReset), 64'd0);
    checkOutput("rst_rden", sqRden, 64'd0);
    checkOutput("rst_sel", 64'(sqSel), 64'd0);
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
    checkOutput("rst_movecount", 64'(moveCount), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset while a move is presented and the consumer takes it on the reset edge.
    begin
      int guard;
      sqDone        = '1;
      ready_default = 1'b0;
      stall_left    = 0;
      load_square(5, 1, 8'hFF);
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (!mvValid && guard < 300) begin
        tick();
        guard++;
      end
      checkOutput("emit_reached", 64'(mvValid), 64'd1);
      reset   = 1'b1;
      mvReady = 1'b1;
      tick();
      checkOutput("midrst_valid", 64'(mvValid), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_sqreset", 64'(sqReset), 64'd0);
      checkOutput("midrst_rden", sqRden, 64'd0);
      checkOutput("midrst_sel", 64'(sqSel), 64'd0);
      checkOutput("midrst_movecount", 64'(moveCount), 64'd0);
      reset = 1'b0;
      word_q.delete();
      word_sq.delete();
      exp_q.delete();
      update_empty();
      tick();
      checkOutput("post_rst_idle", 64'(busy), 64'd0);
      applyStimulus(vecs[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
